conv3x3_sched: RTL and testbench

- Sequencer for the 3x3 PE array (`pe_array_3x3`).
- Accepts a job start, then serially loads 9 filter words and 25 ifmap words into operand registers that drive the array's flat buses.
- Clears the array, runs it for a fixed number of cycles, captures `sum_out_flat`, then streams the 9 results out over a valid/ready port.
- Sits between the DMA/load front end and the array.

---
 rtl/pe_pkg.sv | 34 +++
 rtl/word_shift_loader.sv | 40 ++++
 rtl/conv3x3_sched.sv | 182 ++++++++++++++++++
 tb/tb_conv3x3_sched.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_pkg
//  Description : Shared constants and scheduler state type for the 3x3 PE
//                array and its sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

    // Data word and job geometry
    localparam int c_dw         = 16;
    localparam int c_arr_dim    = 3;
    localparam int c_if_dim     = 5;
    localparam int c_f_n        = c_arr_dim * c_arr_dim;
    localparam int c_if_n       = c_if_dim * c_if_dim;
    localparam int c_run_cycles = 4;

    // Counter widths, sized so that no count ever wraps
    localparam int c_wcnt_w     = 5;
    localparam int c_rcnt_w     = 8;
    localparam int c_idx_w      = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_F = 3'd1,
        S_LOAD_I = 3'd2,
        S_CLR    = 3'd3,
        S_RUN    = 3'd4,
        S_CAPT   = 3'd5,
        S_DRAIN  = 3'd6
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/word_shift_loader.sv
`default_nettype none
// ============================================================================
//  Module      : word_shift_loader
//  Description : Counter-addressed operand register file. The word presented
//                on din is written to slot addr when we is high; all slots
//                are exposed as one flat bus and hold until overwritten.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_shift_loader #(
    parameter int DW = 16,
    parameter int N  = 9,
    parameter int AW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   din,
    output logic [N*DW-1:0] flat
);

    logic [N*DW-1:0] r_flat;

    // Write the addressed slot; every other slot keeps its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flat <= '0;
        end else if (we) begin
            for (int k = 0; k < N; k++) begin
                if (int'(addr) == k) begin
                    r_flat[k*DW +: DW] <= din;
                end
            end
        end
    end

    assign flat = r_flat;

endmodule
`default_nettype wire

// File: rtl/conv3x3_sched.sv
`default_nettype none
// ============================================================================
//  Module      : conv3x3_sched
//  Description : Job sequencer for the 3x3 PE array. Loads filter and ifmap
//                words into operand registers, clears and runs the array for
//                a fixed number of cycles, captures its result bus and
//                streams the result words out over a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv3x3_sched
    import pe_pkg::*;
#(
    parameter int DW         = c_dw,
    parameter int F_N        = c_f_n,
    parameter int IF_N       = c_if_n,
    parameter int RUN_CYCLES = c_run_cycles
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DW-1:0]      in_data,
    output logic               arr_en,
    output logic               arr_rst,
    output logic [F_N*DW-1:0]  arr_filter_flat,
    output logic [IF_N*DW-1:0] arr_ifmap_flat,
    input  logic [F_N*DW-1:0]  arr_sum_flat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [3:0]         out_idx
);

    localparam logic [c_wcnt_w-1:0] c_f_last   = c_wcnt_w'(F_N - 1);
    localparam logic [c_wcnt_w-1:0] c_i_last   = c_wcnt_w'(IF_N - 1);
    localparam logic [c_rcnt_w-1:0] c_run_last = c_rcnt_w'(RUN_CYCLES - 1);
    localparam logic [c_idx_w-1:0]  c_idx_last = c_idx_w'(F_N - 1);

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic [c_wcnt_w-1:0]   r_wcnt;
    logic [c_rcnt_w-1:0]   r_run;
    logic [c_idx_w-1:0]    r_idx;
    logic [F_N*DW-1:0]     r_result;
    logic                  r_done;
    logic                  w_take;
    logic                  w_accept;
    logic                  w_we_f;
    logic                  w_we_i;

    // A load word or result word only moves when abort is not pulling us out.
    assign w_take   = in_ready & in_valid & ~abort;
    assign w_accept = out_valid & out_ready & ~abort;
    assign w_we_f   = w_take & (r_state == S_LOAD_F);
    assign w_we_i   = w_take & (r_state == S_LOAD_I);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state array/handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        in_ready    = 1'b0;
        arr_en      = 1'b0;
        arr_rst     = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy    = 1'b0;
                arr_rst = 1'b1;
                if (start) w_state_nxt = S_LOAD_F;
            end
            S_LOAD_F: begin
                arr_rst  = 1'b1;
                in_ready = 1'b1;
                if (in_valid && (r_wcnt == c_f_last)) w_state_nxt = S_LOAD_I;
            end
            S_LOAD_I: begin
                arr_rst  = 1'b1;
                in_ready = 1'b1;
                if (in_valid && (r_wcnt == c_i_last)) w_state_nxt = S_CLR;
            end
            S_CLR: begin
                arr_rst     = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                arr_en = 1'b1;
                if (r_run == c_run_last) w_state_nxt = S_CAPT;
            end
            S_CAPT: begin
                w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && (r_idx == c_idx_last)) w_state_nxt = S_IDLE;
            end
            default: begin
                busy        = 1'b0;
                arr_rst     = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
        // Abort overrides every transition, including a start in IDLE.
        if (abort) w_state_nxt = S_IDLE;
    end

    // Word/run/drain counters, result capture and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt   <= '0;
            r_run    <= '0;
            r_idx    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_accept && (r_idx == c_idx_last);

            if ((r_state == S_IDLE) && start) begin
                r_wcnt <= '0;
            end else if (w_take) begin
                r_wcnt <= ((r_state == S_LOAD_F) && (r_wcnt == c_f_last)) ? '0 : r_wcnt + 1'b1;
            end

            if (r_state == S_CLR) begin
                r_run <= '0;
            end else if (r_state == S_RUN) begin
                r_run <= r_run + 1'b1;
            end

            if (r_state == S_CAPT) begin
                r_result <= arr_sum_flat;
                r_idx    <= '0;
            end else if (w_accept) begin
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end
        end
    end

    word_shift_loader #(
        .DW (DW),
        .N  (F_N),
        .AW (c_wcnt_w)
    ) u_filter_loader (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_we_f),
        .addr  (r_wcnt),
        .din   (in_data),
        .flat  (arr_filter_flat)
    );

    word_shift_loader #(
        .DW (DW),
        .N  (IF_N),
        .AW (c_wcnt_w)
    ) u_ifmap_loader (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_we_i),
        .addr  (r_wcnt),
        .din   (in_data),
        .flat  (arr_ifmap_flat)
    );

    assign done     = r_done;
    assign out_data = r_result[r_idx*DW +: DW];
    assign out_idx  = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv3x3_sched
//  Description : Self-checking bench for conv3x3_sched with a behavioural
//                3x3 array model and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv3x3_sched;
    import pe_pkg::*;

    localparam int DW         = 16;
    localparam int F_N        = 9;
    localparam int IF_N       = 25;
    localparam int RUN_CYCLES = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               busy;
    logic               done;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [DW-1:0]      in_data = '0;
    logic               arr_en;
    logic               arr_rst;
    logic [F_N*DW-1:0]  arr_filter_flat;
    logic [IF_N*DW-1:0] arr_ifmap_flat;
    logic [F_N*DW-1:0]  arr_sum_flat;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [DW-1:0]      out_data;
    logic [3:0]         out_idx;

    conv3x3_sched #(
        .DW         (DW),
        .F_N        (F_N),
        .IF_N       (IF_N),
        .RUN_CYCLES (RUN_CYCLES)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .busy            (busy),
        .done            (done),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .arr_en          (arr_en),
        .arr_rst         (arr_rst),
        .arr_filter_flat (arr_filter_flat),
        .arr_ifmap_flat  (arr_ifmap_flat),
        .arr_sum_flat    (arr_sum_flat),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_idx         (out_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Valid 3x3 convolution over a 5x5 ifmap, 16-bit wrapping accumulation.
    function automatic logic [F_N*DW-1:0] conv(input logic [F_N*DW-1:0] f,
                                               input logic [IF_N*DW-1:0] x);
        logic [F_N*DW-1:0] r;
        logic [DW-1:0]     acc;
        logic [DW-1:0]     fw;
        logic [DW-1:0]     xw;
        r = '0;
        for (int orow = 0; orow < 3; orow++) begin
            for (int ocol = 0; ocol < 3; ocol++) begin
                acc = '0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        fw  = f[(i*3+j)*DW +: DW];
                        xw  = x[((orow+i)*5 + ocol + j)*DW +: DW];
                        acc = acc + DW'(fw * xw);
                    end
                end
                r[(orow*3+ocol)*DW +: DW] = acc;
            end
        end
        return r;
    endfunction

    // Array model: the result bus is only meaningful after exactly
    // RUN_CYCLES enabled cycles since the last array reset.
    int model_cnt = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       model_cnt <= 0;
        else if (arr_rst) model_cnt <= 0;
        else if (arr_en)  model_cnt <= model_cnt + 1;
    end
    always_comb begin
        arr_sum_flat = '0;
        if (model_cnt == RUN_CYCLES) arr_sum_flat = conv(arr_filter_flat, arr_ifmap_flat);
    end

    typedef struct packed {
        logic [3:0]    idx;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    logic [F_N*DW-1:0]  stim_f;
    logic [IF_N*DW-1:0] stim_x;

    // Monitor state, written only by the monitor process.
    int                done_total      = 0;
    int                en_total        = 0;
    int                clr_total       = 0;
    int                en_rise_cyc     = 0;
    int                ov_rise_cyc     = 0;
    int                last_accept_cyc = -10;
    logic              prev_en         = 1'b0;
    logic              prev_ov         = 1'b0;
    logic [F_N*DW-1:0] capt_val        = '0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (arr_en) en_total++;
                if (arr_en && !prev_en) en_rise_cyc = cyc;
                if (busy && arr_rst && !in_ready) clr_total++;
                if (busy && !arr_en && !arr_rst && !out_valid) capt_val = arr_sum_flat;
                if (out_valid && !prev_ov) ov_rise_cyc = cyc;
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        check_eq("spurious_out", out_valid, 1'b0);
                    end else begin
                        check_eq("out_idx", out_idx, sb[0].idx);
                        check_eq("out_data", out_data, sb[0].data);
                        if (out_ready) begin
                            if (sb[0].idx == 4'd8) last_accept_cyc = cyc;
                            void'(sb.pop_front());
                        end
                    end
                end
                if (done) begin
                    done_total++;
                    check_eq("done_timing", cyc, last_accept_cyc + 1);
                    check_eq("done_in_idle", busy, 1'b0);
                end
            end
            prev_en = arr_en;
            prev_ov = out_valid;
        end
    end

    task automatic set_stim(input int mode);
        for (int k = 0; k < F_N; k++)
            stim_f[k*DW +: DW] = (mode == 0) ? DW'(1) : DW'(k + 1);
        for (int k = 0; k < IF_N; k++)
            stim_x[k*DW +: DW] = (mode == 0) ? DW'(k + 1) : DW'(k * 7 + 3);
    endtask

    // Feeds nwords load words starting just after a posedge; returns the
    // number of cycles with in_valid low and cycles where in_ready was low.
    task automatic drive_load(input bit stall, input int nwords, output int idle, output int bad);
        int n;
        bit ph;
        n = 0; idle = 0; bad = 0; ph = 1'b0;
        while (n < nwords) begin
            in_valid = stall ? !ph : 1'b1;
            ph       = !ph;
            in_data  = (n < F_N) ? stim_f[n*DW +: DW] : stim_x[(n-F_N)*DW +: DW];
            if (!in_valid) idle++;
            @(negedge clk);
            if (!in_ready) bad++;
            @(posedge clk);
            if (in_valid) n++;
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_full_job(input bit stall, input int bp_at, input int bp_len);
        int c0, idle, bad, d0, e0, cl0, hold, n;
        logic [F_N*DW-1:0] expv;
        expv = conv(stim_f, stim_x);
        for (int k = 0; k < F_N; k++) sb.push_back({4'(k), expv[k*DW +: DW]});
        d0 = done_total; e0 = en_total; cl0 = clr_total;
        start = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        drive_load(stall, F_N + IF_N, idle, bad);
        check_eq("in_ready_load", bad, 0);
        hold = 0; n = 0;
        while (done_total == d0 && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (out_valid && (out_idx == 4'(bp_at)) && (hold < bp_len)) begin
                out_ready = 1'b0;
                hold++;
                start = (hold == 2);
            end else begin
                out_ready = 1'b1;
                start     = 1'b0;
            end
        end
        out_ready = 1'b1;
        start     = 1'b0;
        check_eq("done_count", done_total - d0, 1);
        check_eq("arr_en_cycles", en_total - e0, RUN_CYCLES);
        check_eq("clr_cycles", clr_total - cl0, 1);
        check_eq("run_entry", en_rise_cyc - c0, 36 + idle);
        check_eq("first_valid", ov_rise_cyc - c0, 41 + idle);
        check_eq("capture", capt_val, expv);
        check_eq("filter_regs", arr_filter_flat, stim_f);
        check_eq("ifmap_regs", arr_ifmap_flat, stim_x);
        check_eq("sb_empty", sb.size(), 0);
        @(posedge clk); #1;
        check_eq("idle_after_done", busy, 1'b0);
    endtask

    initial begin : main
        int idle, bad, d0, n;
        // Reset values while rst_n is held low
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_arr_en", arr_en, 1'b0);
        check_eq("rst_arr_rst", arr_rst, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_data", out_data, 16'd0);
        check_eq("rst_out_idx", out_idx, 4'd0);
        check_eq("rst_filter", arr_filter_flat, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic job: outputs 63,72,81,108,117,126,153,162,171
        set_stim(0);
        run_full_job(1'b0, -1, 0);

        // Load stalls: in_valid toggles every cycle
        run_full_job(1'b1, -1, 0);

        // Backpressure at idx 3 for 5 cycles, start pulsed during DRAIN
        run_full_job(1'b0, 3, 5);

        // Abort after 12 load words
        set_stim(1);
        d0 = done_total;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drive_load(1'b0, 12, idle, bad);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_in_ready", in_ready, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("abort_no_done", done_total - d0, 0);
        check_eq("abort_partial", arr_ifmap_flat[2*DW +: DW], stim_x[2*DW +: DW]);
        check_eq("abort_filter_kept", arr_filter_flat, stim_f);

        // Abort and start together in IDLE: stay IDLE
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check_eq("abort_wins", busy, 1'b0);

        // Fresh full job after the abort
        run_full_job(1'b0, -1, 0);

        // Asynchronous reset during RUN
        set_stim(0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drive_load(1'b0, F_N + IF_N, idle, bad);
        n = 0;
        while (!arr_en && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("reach_run", arr_en, 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_arr_rst", arr_rst, 1'b1);
        check_eq("mid_rst_arr_en", arr_en, 1'b0);
        check_eq("mid_rst_out_valid", out_valid, 1'b0);
        check_eq("mid_rst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check_eq("post_rst_idle", busy, 1'b0);
        check_eq("post_rst_no_out", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
